// File: rtl/adc_axis_packetizer_pkg.sv
// adc_pkt_pkg: shared definitions for the ADC AXI-Stream packetizer.
//   MAGIC          header sync field
//   pkt_state_e    packetizer FSM states
//   HDR_*_LSB      header field offsets (magic/seq/len/flags)
//   FLAG_EARLY     flags bit set when a capture closed a short packet
//   build_header   assembles the 64-bit header word
//   clamp_len      maps a requested length onto 1..max_len
package adc_pkt_pkg;

  localparam logic [15:0] MAGIC = 16'hADC0;
  localparam int AXIS_W = 64;
  localparam int KEEP_W = AXIS_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_HDR   = 2'd2,
    S_DRAIN = 2'd3
  } pkt_state_e;

  localparam int HDR_MAGIC_LSB = 48;
  localparam int HDR_SEQ_LSB   = 32;
  localparam int HDR_LEN_LSB   = 16;
  localparam int HDR_FLAGS_LSB = 0;
  localparam int FLAG_EARLY    = 0;

  function automatic logic [AXIS_W-1:0] build_header(input logic [15:0] magic,
                                                     input logic [15:0] seq,
                                                     input logic [15:0] len,
                                                     input logic        early);
    logic [AXIS_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 16] = magic;
    h[HDR_SEQ_LSB +: 16]   = seq;
    h[HDR_LEN_LSB +: 16]   = len;
    h[HDR_FLAGS_LSB + FLAG_EARLY] = early;
    return h;
  endfunction

  // Zero or oversize requests fall back to the full buffer depth.
  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] max_len);
    return ((len == 16'd0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/adc_axis_packetizer_if.sv
// adc_axis_packetizer_if: both AXI-Stream channels of the packetizer.
//   s_axis_*  ADC words into the packetizer (tdata/tvalid/tlast, tready back)
//   m_axis_*  framed packets out (tdata/tvalid/tlast/tkeep, tready back)
// Modports:
//   slave   the packetizer's view (sinks s_axis, sources m_axis)
//   master  the surrounding logic's view (sources s_axis, sinks m_axis)
interface adc_axis_packetizer_if;
  import adc_pkt_pkg::*;

  logic [AXIS_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;

  logic [AXIS_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tkeep
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tkeep
  );

endinterface

// File: rtl/adc_axis_packetizer_buf.sv
// adc_pkt_buf: packet store, one write port and one synchronous read port.
//   aclk     clock
//   wr_en    write strobe, wr_addr/wr_data  word to store
//   rd_en    read strobe, rd_addr  word to fetch
//   rd_data  registered read data; holds its value while rd_en is low
module adc_pkt_buf #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_axis_packetizer.sv
// adc_axis_packetizer: store-and-forward framer for 64-bit ADC words.
// Collects pkt_len words (or fewer, if the capture ends with s_axis_tlast),
// then emits a header word followed by the stored payload, tlast on the
// final payload word.
//   aclk, aresetn  clock, asynchronous active-low reset
//   enable         allows a new packet to start
//   pkt_len        payload length, sampled when a packet starts
//   axis           s_axis input stream, m_axis framed output stream
//   pkt_seq        sequence number carried by the next header
//   busy           high while a packet is being emitted
module adc_axis_packetizer
  import adc_pkt_pkg::*;
#(
  parameter int          DATA_WIDTH    = 64,
  parameter int          PKT_WORDS_MAX = 256,
  parameter int          ADDR_WIDTH    = 8,
  parameter logic [15:0] MAGIC         = adc_pkt_pkg::MAGIC
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic [15:0]          pkt_len,
  adc_axis_packetizer_if.slave axis,
  output logic [15:0]          pkt_seq,
  output logic                 busy
);

  pkt_state_e state, state_d;

  // wr_cnt counts stored words; it stays at n_words through HDR/DRAIN.
  logic [ADDR_WIDTH:0]   wr_cnt;
  logic [ADDR_WIDTH:0]   wr_nxt;
  logic [15:0]           wr_nxt16;
  logic [15:0]           len_q;
  logic [15:0]           len_clamped;
  logic                  early_q;
  logic [ADDR_WIDTH-1:0] rd_idx;    // index of the word held in rd_data
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  beat;
  logic                  close_beat;
  logic                  drain_last;

  assign wr_nxt      = wr_cnt + 1'b1;
  assign wr_nxt16    = 16'(wr_nxt);
  assign len_clamped = clamp_len(pkt_len, 16'(PKT_WORDS_MAX));
  assign beat        = (state == S_FILL) && axis.s_axis_tvalid;
  assign close_beat  = beat && ((wr_nxt16 == len_q) || axis.s_axis_tlast);
  assign drain_last  = (state == S_DRAIN) && ({1'b0, rd_idx} == (wr_cnt - 1'b1));

  adc_pkt_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (PKT_WORDS_MAX),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buf (
    .aclk    (aclk),
    .wr_en   (beat),
    .wr_addr (wr_cnt[ADDR_WIDTH-1:0]),
    .wr_data (axis.s_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The RAM read register doubles as the prefetch stage: a read is issued
  // only on an output handshake, so rd_data holds the presented word through
  // any stall and the next word lands exactly one cycle after a handshake.
  always_comb begin
    state_d = state;
    rd_en   = 1'b0;
    rd_addr = rd_idx + 1'b1;
    unique case (state)
      S_IDLE:  if (enable) state_d = S_FILL;
      S_FILL:  if (close_beat) state_d = S_HDR;
      S_HDR: begin
        rd_addr = '0;
        if (axis.m_axis_tready) begin
          rd_en   = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (axis.m_axis_tready) begin
          if (drain_last) state_d = S_IDLE;
          else            rd_en   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      wr_cnt  <= '0;
      len_q   <= '0;
      early_q <= 1'b0;
      pkt_seq <= '0;
      rd_idx  <= '0;
    end else begin
      state <= state_d;
      if ((state == S_IDLE) && enable) len_q <= len_clamped;
      if (beat) begin
        wr_cnt <= wr_nxt;
        if (close_beat) early_q <= axis.s_axis_tlast && (wr_nxt16 < len_q);
      end
      if ((state == S_HDR) && axis.m_axis_tready) begin
        rd_idx <= '0;
      end else if ((state == S_DRAIN) && axis.m_axis_tready) begin
        if (drain_last) begin
          wr_cnt  <= '0;
          pkt_seq <= pkt_seq + 1'b1;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from registered state, so reset clears them at once.
  assign axis.s_axis_tready = (state == S_FILL);
  assign axis.m_axis_tvalid = (state == S_HDR) || (state == S_DRAIN);
  assign axis.m_axis_tlast  = drain_last;
  assign axis.m_axis_tkeep  = axis.m_axis_tvalid ? {KEEP_W{1'b1}} : '0;
  assign axis.m_axis_tdata  = (state == S_HDR)   ? build_header(MAGIC, pkt_seq, 16'(wr_cnt), early_q) :
                              (state == S_DRAIN) ? rd_data : '0;
  assign busy               = axis.m_axis_tvalid;

endmodule

// File: doc/adc_axis_packetizer.md
# adc_axis_packetizer

Store-and-forward framer directly downstream of the FMC150 ADC AXI-Stream output on the `aclk` domain. It accepts 64-bit ADC words (`{counter[31:0], I[15:0], Q[15:0]}`) and groups them into packets of a programmable length. Each packet is emitted with a leading header word and `tlast` on its final data word, ready for the Ethernet/host transmit path. A capture that ends early (upstream `tlast` from `adc_enable` falling) closes a short packet, and the header reports the true length.

## Interface
Parameters:
- `DATA_WIDTH`, 64: stream width; fixed at 64 (the header layout depends on it).
- `PKT_WORDS_MAX`, 256: buffer depth, in words; maximum payload length.
- `ADDR_WIDTH`, 8: `clog2(PKT_WORDS_MAX)`.
- `MAGIC`, 16'hADC0: header sync field.

Ports:
- `aclk`  in  1  single clock for the whole block.
- `aresetn`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  permits the start of a new packet.
- `pkt_len`  in  16  payload words per packet; sampled at packet start.
- `s_axis_tdata`  in  64  ADC word.
- `s_axis_tvalid`  in  1  slave valid.
- `s_axis_tlast`  in  1  end of capture.
- `s_axis_tready`  out  1  slave ready.
- `m_axis_tdata`  out  64  header or payload word.
- `m_axis_tvalid`  out  1  master valid.
- `m_axis_tlast`  out  1  last payload word of the packet.
- `m_axis_tkeep`  out  8  constant 8'hFF whenever `m_axis_tvalid` is high; 0 otherwise.
- `m_axis_tready`  in  1  master ready.
- `pkt_seq`  out  16  sequence number of the next header.
- `busy`  out  1  high in HDR or DRAIN.

## Operation
- States: IDLE, FILL, HDR, DRAIN.
- IDLE:
  - `s_axis_tready` = 0.
  - Transition to FILL when `enable` = 1.
  - On entry to FILL, latch `len_q`: `pkt_len` = 0 or `pkt_len` > `PKT_WORDS_MAX` gives `PKT_WORDS_MAX`; otherwise `pkt_len`.
- FILL:
  - `s_axis_tready` = 1.
  - Each accepted beat is written to `buf[wr_cnt]` and increments `wr_cnt`.
  - The packet closes on the beat where `wr_cnt+1 == len_q` or `s_axis_tlast` = 1, whichever comes first. `s_axis_tlast` on the final count beat is the same close.
  - Set `early` = `s_axis_tlast` && (`wr_cnt+1 < len_q`).
  - Transition to HDR.
- HDR:
  - Present header `{MAGIC, pkt_seq, n_words[15:0], 15'b0, early}`, where `n_words` = words stored.
  - On handshake, transition to DRAIN.
- DRAIN:
  - Emit `buf[0..n_words-1]` in order, one word per handshake.
  - `m_axis_tlast` = 1 on word `n_words-1`.
  - On that handshake: `pkt_seq` += 1 (wraps 16'hFFFF→0), `wr_cnt` ← 0, transition to IDLE.
- `enable` deasserting mid-FILL does not abort; the packet completes by count or upstream `tlast`.
- No data is dropped; upstream is back-pressured (`s_axis_tready` = 0) outside FILL.
- Empty packets never occur: FILL only closes on an accepted beat.

## Timing
- Reset (`aresetn` low, asynchronous):
  - state = IDLE.
  - `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `busy` = 0.
  - `m_axis_tdata` = 0, `m_axis_tkeep` = 0.
  - `pkt_seq` = 0, `wr_cnt` = 0.
- IDLE→FILL: `s_axis_tready` rises 1 cycle after `enable` is sampled high.
- Closing beat accepted at cycle t:
  - `s_axis_tready` = 0 at t+1.
  - Header `m_axis_tvalid` = 1 at t+1.
- Output handshake rules:
  - AXI-Stream: `m_axis_tdata`, `m_axis_tlast` and `m_axis_tkeep` are stable while `tvalid && !tready`.
  - `m_axis_tvalid` never drops without a handshake.
- Buffer read: synchronous (1-cycle). A prefetch register holds the next word so that DRAIN sustains 1 word/cycle with `m_axis_tready` held high.
- Packet of N words with `tready` = 1: N+1 output cycles (header + N).
- Total for a full packet: fill N cycles + header 1 cycle + drain N cycles.
- Last DRAIN handshake at cycle d: IDLE at d+1; `s_axis_tready` = 1 at d+2 if `enable` = 1.

## Structure
- Shared package `adc_pkt_pkg` holds:
  - `MAGIC`.
  - State enum.
  - Header field offsets: magic [63:48], seq [47:32], len [31:16], flags [15:0].
  - Flag bit `FLAG_EARLY` = 0.
- Sub-module `adc_pkt_buf`: single-port-write/single-port-read synchronous RAM, `PKT_WORDS_MAX` × 64, inferred as block RAM.
- The FSM, counters, prefetch register and header mux live in the top level.

## Test plan
- `pkt_len` = 4, `enable` = 1, continuous input words 0x10..0x17 with `tready` = 1:
  - Packet 1: header {ADC0, 0000, 0004, 0000}, then 0x10–0x13, `tlast` on 0x13.
  - Packet 2: header seq 0001, then 0x14–0x17.
- `pkt_len` = 8, `s_axis_tlast` on the 3rd word (0x20, 0x21, 0x22) → header {ADC0, seq, 0003, 0001}, then three words, `tlast` on 0x22.
- `pkt_len` = 0 and `pkt_len` = 1000 → both produce 256-word packets with length field 0x0100.
- Random `m_axis_tready` (50 %) on a 16-word packet:
  - Data and `tlast` are held stable during stalls.
  - Output order is exact.
  - `s_axis_tready` stays 0 until the drain completes.
- `aresetn` asserted mid-DRAIN (word 5 of 16):
  - All outputs are 0 immediately.
  - `pkt_seq` = 0.
  - After release, the next packet's header has seq 0000.
- `pkt_seq` preloaded by running 65536 one-word packets → the header after 0xFFFF carries seq 0x0000.
